np_out_arbiter_rr: RTL

Packet-level round-robin output arbiter for the network-processor core: merges `NUM_IN` PPU output channels (req/ack/bop/eop handshake) onto the single NetFPGA output stream (`out_data`/`out_ctrl`/`out_wr`/`out_rdy`). It is the parametrised successor of the fixed two-input `out_arbiter` and sits between `ppu` and the user data path output. It adds:
- arbitrary channel count and width;
- fair rotating priority;
- ctrl pass-through;
- protocol-error detection;
- optional per-channel packet counters.

---
 rtl/np_out_arbiter_rr.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/np_out_arbiter_rr.sv
// np_out_arbiter_rr: packet-level round-robin arbiter merging NUM_IN PPU channels onto one output stream.
// Optional per-channel packet counters are built when the macro NP_OA_PKT_CNT_EN is defined.
module np_out_arbiter_rr #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int NUM_IN     = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_IN*CTRL_WIDTH-1:0] in_ctrl,
   input  logic [NUM_IN-1:0]            in_wr,
   input  logic [NUM_IN-1:0]            in_req,
   output logic [NUM_IN-1:0]            in_ack,
   input  logic [NUM_IN-1:0]            in_bop,
   input  logic [NUM_IN-1:0]            in_eop,
   output logic [NUM_IN-1:0]            in_outrdy,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CTRL_WIDTH-1:0]        out_ctrl,
   output logic                         out_wr,
   input  logic                         out_rdy,
   output logic                         proto_err,
   output logic [NUM_IN*CNT_WIDTH-1:0]  pkt_cnt
);
   localparam int              IW       = $clog2(NUM_IN);
   localparam logic [IW:0]     NUM_IN_W = (IW+1)'(NUM_IN);
   localparam logic [IW-1:0]   LAST_CH  = IW'(NUM_IN - 1);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t                  state, state_nxt;
   logic [IW-1:0]           grant, grant_nxt;
   logic [IW-1:0]           rr_ptr, rr_ptr_nxt;
   logic                    first_word, first_word_nxt;
   logic                    found;
   logic [IW-1:0]           pick;
   logic [IW:0]             scan_idx;
   logic [DATA_WIDTH-1:0]   cur_data;
   logic [CTRL_WIDTH-1:0]   cur_ctrl;
   logic                    cur_wr, cur_bop, cur_eop;
   logic                    accept, err_now;

   // Rotating-priority scan: first requester at or after rr_ptr, wrapping modulo NUM_IN.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
         if (scan_idx >= NUM_IN_W) scan_idx = scan_idx - NUM_IN_W;
         if (!found && in_req[scan_idx[IW-1:0]]) begin
            found = 1'b1;
            pick  = scan_idx[IW-1:0];
         end
      end
   end

   always_comb begin
      cur_data = '0;
      cur_ctrl = '0;
      cur_wr   = 1'b0;
      cur_bop  = 1'b0;
      cur_eop  = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (grant == IW'(k)) begin
            cur_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            cur_ctrl = in_ctrl[k*CTRL_WIDTH +: CTRL_WIDTH];
            cur_wr   = in_wr[k];
            cur_bop  = in_bop[k];
            cur_eop  = in_eop[k];
         end
      end
   end

   always_comb begin
      in_ack    = '0;
      in_outrdy = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         in_ack[k]    = (state == XFER) && (grant == IW'(k));
         in_outrdy[k] = in_ack[k] && out_rdy;
      end
   end

   assign accept = (state == XFER) && cur_wr && out_rdy;
   // bop must appear on exactly the first accepted word of a grant; strays are flagged but ignored.
   assign err_now = (accept && (first_word != cur_bop)) || (|(in_wr & ~in_ack));

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      rr_ptr_nxt     = rr_ptr;
      first_word_nxt = first_word;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt      = XFER;
               grant_nxt      = pick;
               first_word_nxt = 1'b1;
            end
         end
         XFER: begin
            if (accept) begin
               first_word_nxt = 1'b0;
               if (cur_eop) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = (grant == LAST_CH) ? '0 : grant + IW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         rr_ptr     <= '0;
         first_word <= 1'b0;
         out_wr     <= 1'b0;
         out_data   <= '0;
         out_ctrl   <= '0;
         proto_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         rr_ptr     <= rr_ptr_nxt;
         first_word <= first_word_nxt;
         out_wr     <= accept;
         if (accept) begin
            out_data <= cur_data;
            out_ctrl <= cur_ctrl;
         end
         if (err_now) proto_err <= 1'b1;
      end
   end

`ifdef NP_OA_PKT_CNT_EN
   logic [CNT_WIDTH-1:0] cnt [NUM_IN];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_IN; k++) cnt[k] <= '0;
      end else if (accept && cur_eop) begin
         cnt[grant] <= cnt[grant] + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      pkt_cnt = '0;
      for (int k = 0; k < NUM_IN; k++) pkt_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
   end
`else
   assign pkt_cnt = '0;
`endif

endmodule
